// File: rtl/rf_mp_scoreboard.sv
// rf_mp_scoreboard: multi-port general register file with a per-register busy scoreboard.
// - NRD combinational read ports, NWR write ports, same-cycle write-to-read bypass.
// - After reset, a sweep zeroes one entry per cycle. Storage is never reset directly,
//   so it can map onto RAM-style arrays.
// - Optional write trace: define RF_MP_TRACE_EN to print every effective write in RUN.
module rf_mp_scoreboard #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic              init_busy
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] CNT_MAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [AW-1:0]     sweep_cnt;
    logic [DW-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [NWR-1:0]    wr_eff;

    // Entry 0 is the hardwired zero register when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Sweep sequencer: INIT walks the counter to CNT_MAX, then parks in RUN.
    // The counter saturates at CNT_MAX; it is not incremented past it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else if (state == INIT) begin
            if (sweep_cnt == CNT_MAX)
                state <= RUN;
            else
                sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    assign init_busy = (state == INIT);

    // A write takes effect only if it does not target the zero register
    // and no higher-indexed port writes the same address this cycle.
    always_comb begin
        wr_eff = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = wr_en[j] && !is_zero_reg(wr_addr[j*AW +: AW]);
            for (int i = j + 1; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]))
                    wr_eff[j] = 1'b0;
            end
        end
    end

    // Storage: the sweep clears one entry per cycle in INIT, and port writes land in RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (reset_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j])
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
            end
        end
    end

    // Scoreboard next state. Flush dominates everything. Otherwise writes clear
    // their bits, and an issue sets its bit afterwards, so the new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j])
                    busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
            end
            if (iss_en && !is_zero_reg(iss_addr))
                busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Scoreboard register: cleared by reset and frozen while the sweep runs.
    always_ff @(posedge clk) begin
        if (!reset_n)
            busy <= '0;
        else if (state == RUN)
            busy <= busy_nxt;
    end

    // Read ports. Data is bypassed from the highest matching writer; busy is not bypassed.
    always_comb begin
        rd_data = '0;
        rd_busy = '1;
        if (state == RUN) begin
            for (int k = 0; k < NRD; k++) begin
                rd_busy[k] = busy[rd_addr[k*AW +: AW]];
                if (!is_zero_reg(rd_addr[k*AW +: AW])) begin
                    rd_data[k*DW +: DW] = mem[rd_addr[k*AW +: AW]];
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]))
                            rd_data[k*DW +: DW] = wr_data[j*DW +: DW];
                    end
                end
            end
        end
    end

`ifdef RF_MP_TRACE_EN
    // Trace each write that actually updates storage.
    always_ff @(posedge clk) begin
        if (reset_n && (state == RUN)) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j])
                    $display("port %0d: $%d <= %h", j, wr_addr[j*AW +: AW], wr_data[j*DW +: DW]);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Randomized and directed bench for rf_mp_scoreboard, using an array/flag reference model.
module tb_rf_mp_scoreboard;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              flush;
    logic              init_busy;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_mem  [DEPTH];
    bit          m_busy [DEPTH];
    int          m_init_left = DEPTH;
    bit          armed = 1'b0;

    rf_mp_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        rd_addr  = '0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [31:0] d);
        wr_en[j]             = 1'b1;
        wr_addr[j*AW +: AW]  = AW'(a);
        wr_data[j*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    // Reference read: zero during init, zero register, highest-port bypass, else storage.
    function automatic logic [31:0] exp_rd(input int a);
        if (m_init_left > 0) return 32'h0;
        if (a == 0) return 32'h0;
        for (int j = NWR - 1; j >= 0; j--)
            if (wr_en[j] && (int'(wr_addr[j*AW +: AW]) == a)) return wr_data[j*DW +: DW];
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (m_init_left > 0) return 1'b1;
        return m_busy[a];
    endfunction

    task automatic update_model();
        if (!reset_n) begin
            m_init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            armed = 1'b1;
        end else if (m_init_left > 0) begin
            m_mem[DEPTH - m_init_left] = 32'h0;
            m_init_left--;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
                    m_mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
                if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            end
        end
    endtask

    // Compare all outputs against the model mid-cycle, then advance one clock.
    task automatic step();
        @(negedge clk);
        if (armed) begin
            check("init_busy", 32'(init_busy), 32'(m_init_left > 0));
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("rd_data%0d@%0d", k, rd_addr[k*AW +: AW]),
                      rd_data[k*DW +: DW], exp_rd(int'(rd_addr[k*AW +: AW])));
                check($sformatf("rd_busy%0d@%0d", k, rd_addr[k*AW +: AW]),
                      32'(rd_busy[k]), 32'(exp_busy(int'(rd_addr[k*AW +: AW]))));
            end
        end
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        int n;
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Init sweep length, with writes/issues/flush attempted during INIT
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            idle();
            set_rd(1, n % DEPTH);
            if (n == 3 || n == 20) begin
                set_wr(0, 7, 32'hDEADBEEF);
                iss_en = 1'b1; iss_addr = 5'd7; flush = (n == 20);
            end
            step();
            n++;
        end
        check("init_len", 32'(n), 32'd32);
        idle(); set_rd(0, 7); #1;
        check("t1_e7_data", rd_data[31:0], 32'h0);
        check("t1_e7_busy", 32'(rd_busy[0]), 32'd0);
        step();

        // Write with same-cycle bypass
        idle(); set_wr(0, 3, 32'h12345678); set_rd(0, 3); #1;
        check("t2_bypass", rd_data[31:0], 32'h12345678);
        step();
        idle(); set_rd(0, 3); #1;
        check("t2_stored", rd_data[31:0], 32'h12345678);
        step();

        // Port conflict and zero register
        idle(); set_wr(0, 5, 32'hAAAA0000); set_wr(1, 5, 32'h0000BBBB); set_rd(0, 5); #1;
        check("t3_conf_byp", rd_data[31:0], 32'h0000BBBB);
        step();
        idle(); set_rd(0, 5); set_wr(0, 0, 32'hFFFFFFFF); set_rd(1, 0); #1;
        check("t3_conf_mem", rd_data[31:0], 32'h0000BBBB);
        check("t3_zero_byp", rd_data[63:32], 32'h0);
        step();
        idle(); set_rd(1, 0); #1;
        check("t3_zero_mem", rd_data[63:32], 32'h0);
        step();

        // Scoreboard set/clear, not bypassed, issue beats write, zero never busy
        idle(); iss_en = 1'b1; iss_addr = 5'd9; set_rd(0, 9); #1;
        check("t4_pre", 32'(rd_busy[0]), 32'd0);
        step();
        idle(); set_rd(0, 9); set_wr(1, 9, 32'h1); #1;
        check("t4_set", 32'(rd_busy[0]), 32'd1);
        step();
        idle(); set_rd(0, 9); #1;
        check("t4_clr", 32'(rd_busy[0]), 32'd0);
        iss_en = 1'b1; iss_addr = 5'd9; set_wr(0, 9, 32'h2);
        step();
        idle(); set_rd(0, 9); iss_en = 1'b1; iss_addr = 5'd0; #1;
        check("t4_iss_wr", 32'(rd_busy[0]), 32'd1);
        step();
        idle(); set_rd(1, 0); #1;
        check("t4_zero", 32'(rd_busy[1]), 32'd0);
        step();

        // Flush beats same-cycle issue
        idle(); iss_en = 1'b1; iss_addr = 5'd4; step();
        idle(); iss_en = 1'b1; iss_addr = 5'd6; step();
        idle(); set_rd(0, 4); set_rd(1, 6); #1;
        check("t5_b4", 32'(rd_busy[0]), 32'd1);
        check("t5_b6", 32'(rd_busy[1]), 32'd1);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd8;
        step();
        idle(); set_rd(0, 4); set_rd(1, 8); #1;
        check("t5_f4", 32'(rd_busy[0]), 32'd0);
        check("t5_f8", 32'(rd_busy[1]), 32'd0);
        step();

        // Reset mid-operation restarts the sweep
        for (int a = 1; a <= 3; a++) begin
            idle(); set_wr(a % 2, a, 32'hC0DE0000 + 32'(a)); iss_en = 1'b1; iss_addr = AW'(a + 10);
            step();
        end
        idle(); iss_en = 1'b1; iss_addr = 5'd2; step();
        idle(); reset_n = 1'b0; step();
        reset_n = 1'b1;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("t6_init_len", 32'(n), 32'd32);
        for (int a = 1; a <= 3; a++) begin
            idle(); set_rd(0, a); set_rd(1, a + 10); #1;
            check($sformatf("t6_data%0d", a), rd_data[31:0], 32'h0);
            check($sformatf("t6_busy%0d", a), 32'(rd_busy[0]), 32'd0);
            check($sformatf("t6_busyi%0d", a), 32'(rd_busy[1]), 32'd0);
            step();
        end

        // Randomized traffic, narrow address range for frequent collisions
        for (int c = 0; c < 1500; c++) begin
            idle();
            reset_n = ($urandom_range(0, 399) != 0);
            for (int j = 0; j < NWR; j++) begin
                wr_en[j] = ($urandom_range(0, 2) == 0);
                wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                wr_data[j*DW +: DW] = $urandom;
            end
            for (int k = 0; k < NRD; k++)
                rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rf_mp_scoreboard.md
Name: rf_mp_scoreboard

Overview:
Parametrised multi-port general register file for the pipelined CPU, replacing the 2R/1W file.
- N read ports and M write ports.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard that the hazard unit uses for stall decisions.
- Post-reset sequential init sweep that zeroes storage one entry per cycle, so it maps to RAM-style arrays.

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW entries
NRD, 2, number of read ports (1..8)
NWR, 1, number of write ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0, is never written and is never busy

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
rd_addr  in  NRD*AW  read addresses, port k = bits [k*AW +: AW]
rd_data  out  NRD*DW  read data (combinational)
rd_busy  out  NRD  scoreboard busy bit per read port (combinational)
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*DW  write data
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  AW  destination being issued
flush  in  1  clear all busy bits
init_busy  out  1  high while the init sweep runs

Behaviour:
- Clock and reset: one clock, clk; reset is reset_n, synchronous, active-low.
- States: INIT, RUN.
  - reset_n=0 at a clk edge -> state=INIT, sweep counter=0, all busy bits=0.
  - Reset mid-operation (any state) restarts the sweep from 0.
- INIT:
  - Each cycle, entry[counter] <= 0 and counter++.
  - When counter = 2**AW-1 is cleared, go to RUN on the next edge; INIT lasts exactly 2**AW cycles after reset_n rises.
  - init_busy=1; rd_data=0; rd_busy=all 1s.
  - wr_en, iss_en and flush are ignored.
- RUN: init_busy=0.
- Write:
  - At the edge, entry[wr_addr[j]] <= wr_data[j] for every j with wr_en[j].
  - A write to entry 0 is dropped when ZERO_REG=1.
  - Two ports writing the same address in the same cycle: the highest port index wins.
- Read (combinational):
  - rd_addr=0 with ZERO_REG=1 -> 0.
  - Else, if any wr_en[j] has wr_addr[j]==rd_addr -> bypass wr_data of the highest matching j.
  - Else -> stored entry.
- Scoreboard, evaluated at the edge in this priority order:
  1. flush -> all bits 0, and any issue in the same cycle is discarded.
  2. Writes clear busy[wr_addr[j]].
  3. iss_en sets busy[iss_addr].
  - Issue and write to the same address in the same cycle leave the bit set (the new producer wins).
  - The bit for address 0 is never set when ZERO_REG=1.
  - rd_busy[k] = busy[rd_addr[k]] as registered; it is not bypassed, so a write in the current cycle does not clear it until the next cycle.
- Outputs after reset: init_busy=1, rd_data=0, rd_busy=all 1s, until the sweep ends.
- Width rules: no arithmetic beyond the AW-bit sweep counter; the counter stops at 2**AW-1 and does not wrap.

Optional Feature:
Macro RF_MP_TRACE_EN.
- Defined: for every effective write in RUN (not dropped, not overridden by a higher port), $display at the clk edge: "port %0d: $%d <= %h" with port index, address, data.
  - Writes to entry 0 under ZERO_REG are not printed.
  - A write overridden by a higher port is not printed.
- Undefined: no trace code is compiled; functional behaviour is identical.

Test Plan:
1. Init sweep: hold reset_n=0 for 2 cycles, release (AW=5) -> init_busy=1 for exactly 32 cycles; rd_data=0 and rd_busy=all 1s throughout; entry 7 reads 0 afterwards even if wr_en pulsed with data 0xDEADBEEF during INIT.
2. Write/bypass: in RUN, wr_en[0]=1, addr 3, data 0x12345678 with rd_addr[0]=3 in the same cycle -> rd_data port 0 = 0x12345678 combinationally; next cycle with wr_en=0 it still reads 0x12345678.
3. Zero register and conflict (NWR=2): both ports write addr 5 with 0xAAAA0000 / 0x0000BBBB -> entry 5 = 0x0000BBBB; port 0 writing addr 0 with 0xFFFFFFFF -> reads 0.
4. Scoreboard: iss_en addr 9 -> rd_busy=1 next cycle; write to 9 -> busy clears the following cycle; issue and write to 9 in the same cycle -> stays 1; iss_en addr 0 -> never busy.
5. Flush priority: busy bits {4,6} set, then flush=1 with iss_en addr 8 in the same cycle -> all busy bits 0, including 8.
6. Reset mid-operation: assert reset_n=0 during RUN after writes to entries 1..3 -> INIT restarts, 32-cycle sweep, all entries read 0 and busy bits 0 afterwards.
